// File: rtl/d8m_config_seq.sv
// Camera sensor bring-up sequencer: pulses sensor reset, then walks a ROM table of
// register writes through an external I2C master, with retry, timeout and delay entries.
module d8m_config_seq #(
  parameter int unsigned NUM_REGS     = 64,
  parameter int unsigned RST_LOW_CYC  = 50000,
  parameter int unsigned RST_WAIT_CYC = 250000,
  parameter int unsigned TIMEOUT_CYC  = 1000000,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic        CLOCK_50,
  input  logic        RESET_SYS_N,
  input  logic        RECONFIG,
  output logic        oRESET_N,
  output logic [7:0]  ROM_ADDR,
  input  logic [23:0] ROM_DATA,
  output logic        I2C_GO,
  output logic [15:0] I2C_REG,
  output logic [7:0]  I2C_DAT,
  input  logic        I2C_DONE,
  input  logic        I2C_NACK,
  output logic        CFG_DONE,
  output logic        CFG_ERR,
  output logic [7:0]  ERR_INDEX
);

  // One shared counter serves reset timing, fetch phase, delay entries and ack timeout.
  localparam int unsigned DelayMax = 255 * 1024;
  localparam int unsigned Max1     = (RST_LOW_CYC > RST_WAIT_CYC) ? RST_LOW_CYC : RST_WAIT_CYC;
  localparam int unsigned Max2     = (Max1 > TIMEOUT_CYC) ? Max1 : TIMEOUT_CYC;
  localparam int unsigned CntMax   = (Max2 > DelayMax) ? Max2 : DelayMax;
  localparam int unsigned CntW     = $clog2(CntMax + 1);
  localparam int unsigned RetryW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CntW-1:0]   LowLast  = CntW'(RST_LOW_CYC - 1);
  localparam logic [CntW-1:0]   WaitLast = CntW'(RST_WAIT_CYC - 1);
  localparam logic [CntW-1:0]   TmoLast  = CntW'(TIMEOUT_CYC - 1);
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);
  localparam logic [7:0]        LastIdx  = 8'(NUM_REGS - 1);

  typedef enum logic [3:0] {
    StRstLow, StRstWait, StFetch, StIssue, StWaitAck, StNext, StDelay, StDone, StError
  } state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d, cnt_inc, delay_last;
  logic [7:0]         idx_q, idx_d, err_idx_q, err_idx_d;
  logic [RetryW-1:0]  retry_q, retry_d;
  logic [23:0]        ent_q, ent_d;
  logic [15:0]        i2c_reg_q;
  logic [7:0]         i2c_dat_q;
  logic               fail;

  assign cnt_inc    = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  assign delay_last = CntW'({ent_q[7:0], 10'd0} - 18'd1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_inc;
    idx_d     = idx_q;
    retry_d   = retry_q;
    ent_d     = ent_q;
    err_idx_d = err_idx_q;
    fail      = 1'b0;
    unique case (state_q)
      StRstLow: begin
        if (cnt_q == LowLast) begin
          state_d = StRstWait;
          cnt_d   = '0;
        end
      end
      StRstWait: begin
        if (cnt_q == WaitLast) begin
          state_d = StFetch;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      StFetch: begin
        // Second fetch cycle: ROM output now reflects ROM_ADDR.
        if (cnt_q != '0) begin
          ent_d = ROM_DATA;
          cnt_d = '0;
          if (ROM_DATA[23:8] == 16'hFFFF) begin
            state_d = (ROM_DATA[7:0] == 8'd0) ? StNext : StDelay;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        state_d = StWaitAck;
        cnt_d   = '0;
      end
      StWaitAck: begin
        if (I2C_DONE && !I2C_NACK) begin
          state_d = StNext;
          retry_d = '0;
          cnt_d   = '0;
        end else if (I2C_DONE || cnt_q == TmoLast) begin
          fail = 1'b1;
        end
      end
      StNext: begin
        cnt_d = '0;
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = StFetch;
        end
      end
      StDelay: begin
        if (cnt_q == delay_last) begin
          state_d = StNext;
          cnt_d   = '0;
        end
      end
      StDone, StError: cnt_d = '0;
      default: state_d = StRstLow;
    endcase

    if (fail) begin
      cnt_d = '0;
      if (retry_q < RetryMax) begin
        retry_d = retry_q + 1'b1;
        state_d = StIssue;
      end else begin
        err_idx_d = idx_q;
        state_d   = StError;
      end
    end

    if (RECONFIG) begin
      state_d = StRstLow;
      cnt_d   = '0;
      idx_d   = '0;
      retry_d = '0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_SYS_N) begin
    if (!RESET_SYS_N) begin
      state_q   <= StRstLow;
      cnt_q     <= '0;
      idx_q     <= '0;
      retry_q   <= '0;
      ent_q     <= '0;
      err_idx_q <= '0;
      i2c_reg_q <= '0;
      i2c_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      retry_q   <= retry_d;
      ent_q     <= ent_d;
      err_idx_q <= err_idx_d;
      // Write payload only changes as a GO is launched, so it holds between requests.
      if (state_d == StIssue) begin
        i2c_reg_q <= ent_d[23:8];
        i2c_dat_q <= ent_d[7:0];
      end
    end
  end

  assign oRESET_N  = (state_q != StRstLow);
  assign I2C_GO    = (state_q == StIssue);
  assign CFG_DONE  = (state_q == StDone);
  assign CFG_ERR   = (state_q == StError);
  assign ROM_ADDR  = idx_q;
  assign I2C_REG   = i2c_reg_q;
  assign I2C_DAT   = i2c_dat_q;
  assign ERR_INDEX = err_idx_q;

endmodule

// File: doc/d8m_config_seq.md
D8M_CONFIG_SEQ -- requirements
Module: d8m_config_seq

Interface
REQ-001 SHALL have parameter NUM_REGS, default 64, meaning number of configuration table entries (1..256).
REQ-002 SHALL have parameter RST_LOW_CYC, default 50000, meaning sensor reset-low duration in clocks.
REQ-003 SHALL have parameter RST_WAIT_CYC, default 250000, meaning wait after reset release before the first write.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1000000, meaning maximum clocks allowed from GO to DONE.
REQ-005 SHALL have parameter MAX_RETRY, default 3, meaning retries per entry after the first attempt.
REQ-006 SHALL have port CLOCK_50, input, 1 bit: the single clock.
REQ-007 SHALL have port RESET_SYS_N, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port RECONFIG, input, 1 bit: one-cycle pulse that restarts the full sequence.
REQ-009 SHALL have port oRESET_N, output, 1 bit: sensor reset, active-low.
REQ-010 SHALL have port ROM_ADDR, output, 8 bits: configuration table index.
REQ-011 SHALL have port ROM_DATA, input, 24 bits: {reg_addr[23:8], reg_data[7:0]}, valid one clock after ROM_ADDR changes.
REQ-012 SHALL have port I2C_GO, output, 1 bit: one-cycle write request to the I2C master.
REQ-013 SHALL have port I2C_REG, output, 16 bits: register address presented with and held after GO.
REQ-014 SHALL have port I2C_DAT, output, 8 bits: write data presented with and held after GO.
REQ-015 SHALL have port I2C_DONE, input, 1 bit: one-cycle completion pulse from the master.
REQ-016 SHALL have port I2C_NACK, input, 1 bit: failure flag, sampled only on the I2C_DONE cycle.
REQ-017 SHALL have port CFG_DONE, output, 1 bit: level; all entries written.
REQ-018 SHALL have port CFG_ERR, output, 1 bit: level; sequence aborted.
REQ-019 SHALL have port ERR_INDEX, output, 8 bits: index of the entry that failed.

Function
REQ-020 SHALL implement the FSM states RST_LOW, RST_WAIT, FETCH, ISSUE, WAIT_ACK, NEXT, DELAY, DONE and ERROR.
REQ-021 RST_LOW SHALL drive oRESET_N=0 for exactly RST_LOW_CYC clocks, then go to RST_WAIT.
REQ-022 RST_WAIT SHALL drive oRESET_N=1 for RST_WAIT_CYC clocks, then go to FETCH with index 0.
REQ-023 FETCH SHALL drive ROM_ADDR=index, wait one clock, then latch ROM_DATA.
REQ-024 After FETCH, an entry with reg_addr 16'hFFFF SHALL go to DELAY; any other entry SHALL go to ISSUE.
REQ-025 DELAY SHALL wait reg_data*1024 clocks (0 means no wait), then go to NEXT; no I2C_GO SHALL be issued for a delay entry.
REQ-026 ISSUE SHALL assert I2C_GO for exactly one clock with I2C_REG/I2C_DAT valid, then go to WAIT_ACK.
REQ-027 I2C_REG and I2C_DAT SHALL stay stable until the next ISSUE.
REQ-028 WAIT_ACK on I2C_DONE with I2C_NACK=0 SHALL go to NEXT and clear the retry counter.
REQ-029 WAIT_ACK on I2C_DONE with I2C_NACK=1, or when the timeout counter reaches TIMEOUT_CYC, SHALL count a failure.
REQ-030 On a failure with retry count below MAX_RETRY, the FSM SHALL increment the retry count and return to ISSUE (same entry).
REQ-031 On a failure with retry count equal to MAX_RETRY, the FSM SHALL latch ERR_INDEX=index and go to ERROR.
REQ-032 I2C_DONE arriving outside WAIT_ACK SHALL be ignored.
REQ-033 NEXT SHALL go to DONE when index=NUM_REGS-1; otherwise it SHALL increment index and go to FETCH; the index SHALL never wrap.
REQ-034 DONE SHALL set CFG_DONE=1; ERROR SHALL set CFG_ERR=1; CFG_DONE and CFG_ERR SHALL never both be 1.
REQ-035 RECONFIG in any state SHALL, on the next clock, clear CFG_DONE, CFG_ERR, index and retry, and enter RST_LOW.
REQ-036 A RECONFIG arriving in WAIT_ACK SHALL abandon the outstanding transfer.
REQ-037 All counters SHALL be wide enough for their parameter and SHALL saturate, never wrap.

Reset
REQ-038 On RESET_SYS_N=0, asynchronously: state=RST_LOW, oRESET_N=0, I2C_GO=0, ROM_ADDR=0, I2C_REG=0, I2C_DAT=0, CFG_DONE=0, CFG_ERR=0, ERR_INDEX=0, and all counters=0.
REQ-039 After reset release, the sequence SHALL start automatically with no RECONFIG needed.
REQ-040 Reset asserted mid-transfer SHALL abort it with no further I2C_GO.

Verification
REQ-041 NUM_REGS=4 with all entries ACKed -> oRESET_N low for RST_LOW_CYC clocks, exactly 4 GO pulses with table values, then CFG_DONE=1 and CFG_ERR=0.
REQ-042 Entry 2 NACKs every attempt with MAX_RETRY=3 -> 4 GO pulses for entry 2, CFG_ERR=1, ERR_INDEX=2, and entry 3 never issued.
REQ-043 Entry 1 NACKs once, then ACKs -> 2 GO pulses for entry 1, retry counter cleared, CFG_DONE=1.
REQ-044 I2C_DONE never returned, TIMEOUT_CYC=100 -> GO repeated every about 101 clocks, 4 times, then CFG_ERR=1.
REQ-045 Entry {16'hFFFF, 8'd3} -> no GO for that entry and 3072 idle clocks before the next FETCH.
REQ-046 RECONFIG pulsed during WAIT_ACK, then a late I2C_DONE -> late DONE ignored, oRESET_N=0 next clock, and a full sequence reruns from index 0.
